bmc_acs_sched: RTL and testbench
================================

Name: bmc_acs_sched

Overview:
- Frame-level sequencer for the Viterbi decoder's branch-metric / add-compare-select datapath (K=3, 4 states, 2 branches per state).
- Accepts received symbol pairs over a valid/ready handshake and registers each pair onto the shared rx_pair bus feeding the BMC units.
- Time-shares the ACS array across N_GRP state groups per symbol and writes survivor memory once per trellis step.
- Injects K-1 tail flush symbols, then launches traceback and reports frame completion.

Parameters:
- FRAME_LEN, 256, data symbols per frame (>=2).
- TAIL_LEN, 2, flush symbols (K-1) appended after the data symbols.
- N_GRP, 4, ACS groups processed per symbol, one group per cycle (>=1).
- ADDR_W, 9, survivor memory address width; must satisfy 2**ADDR_W >= FRAME_LEN+TAIL_LEN.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a frame; ignored unless in IDLE.
- in_valid  in  1  rx_pair valid.
- in_ready  out  1  block can accept rx_pair this cycle.
- in_rx_pair  in  2  received symbol pair.
- bmc_rx_pair  out  2  registered pair driven to all BMC units.
- pm_init  out  1  one-cycle pulse: ACS path metrics load start-state values.
- acs_en  out  1  ACS group update enable.
- acs_grp  out  clog2(N_GRP) (min 1)  active ACS group index.
- sv_wr_en  out  1  survivor memory write strobe.
- sv_wr_addr  out  ADDR_W  trellis step index being written.
- tb_start  out  1  one-cycle traceback launch pulse.
- tb_done  in  1  traceback complete (level or pulse; sampled only in TB_WAIT).
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: all outputs 0; state=IDLE; step counter=0; bmc_rx_pair=2'b00. Reset asserted mid-frame aborts immediately. No partial write or pulse completes after reset.
- States: IDLE, INIT, SYM_WAIT, ACS, FLUSH, TB_LAUNCH, TB_WAIT, DONE.
- IDLE -> INIT on start. INIT: pm_init=1 for one cycle; step=0; -> SYM_WAIT.
- SYM_WAIT: in_ready=1. On in_valid, latch in_rx_pair into bmc_rx_pair and go to ACS. in_ready is 0 in all other states.
- ACS: N_GRP consecutive cycles; acs_en=1; acs_grp=0..N_GRP-1.
  - On the final group cycle: sv_wr_en=1, sv_wr_addr=step, step increments.
  - Exit from the final group cycle:
    - step (before increment) < FRAME_LEN-1 -> SYM_WAIT.
    - step < FRAME_LEN+TAIL_LEN-1 -> FLUSH.
    - otherwise -> TB_LAUNCH.
- FLUSH: single cycle; bmc_rx_pair<=2'b00; -> ACS. The no-input-wait path is what makes these symbols tail symbols.
- TB_LAUNCH: tb_start=1 for one cycle; -> TB_WAIT.
- TB_WAIT: stays until tb_done=1, then -> DONE. tb_done outside TB_WAIT is ignored.
- DONE: frame_done=1 for one cycle; -> IDLE. start in the DONE cycle is ignored.
- Throughput: one data symbol per N_GRP+1 cycles with in_valid held high.
- Per-frame totals: sv_wr_en pulses = FRAME_LEN+TAIL_LEN; addresses 0..FRAME_LEN+TAIL_LEN-1, strictly incrementing, no wrap within a frame.
- bmc_rx_pair holds stable throughout each ACS group sequence.
- start while busy: ignored, no state effect.
- TAIL_LEN=0: last data symbol goes straight to TB_LAUNCH.
- N_GRP=1: acs_grp constant 0; each ACS visit lasts one cycle.

Optional Feature:
- Macro: BMC_SCHED_STALL_CNT_EN.
- Defined: adds output stall_cnt [15:0].
  - Counts cycles where busy=1 and the state is SYM_WAIT with in_valid=0 (input starvation).
  - Saturates at 16'hFFFF; clears on reset and on the INIT cycle.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset/idle: rst_n=0 with garbage inputs -> all outputs 0. Release reset, no start for 20 cycles -> busy=0, in_ready=0.
- Nominal frame, FRAME_LEN=4, TAIL_LEN=2, N_GRP=4, in_valid held high with pairs 01,10,11,00:
  - start -> pm_init 1 cycle later; in_ready on the next cycle.
  - sv_wr_addr 0..5 observed; addresses 4,5 carry bmc_rx_pair=00 with in_ready=0.
  - tb_start 1 cycle after the last write.
  - tb_done held 3 cycles later -> frame_done 1 cycle after tb_done is sampled.
- Backpressure: drop in_valid for 7 cycles after the second symbol -> FSM holds SYM_WAIT, no acs_en/sv_wr_en. Resume -> addresses continue at 2 with no gap or repeat.
- Spurious controls:
  - start pulsed during ACS -> ignored.
  - tb_done pulsed during SYM_WAIT -> ignored; traceback still waits for a real tb_done.
  - Second start after frame_done -> new frame restarts at address 0.
- Mid-frame reset: assert rst_n=0 during the third ACS group cycle -> outputs 0 immediately, no sv_wr_en. Next start -> clean frame from address 0.
- BMC_SCHED_STALL_CNT_EN: 5 starved cycles in frame 1 -> stall_cnt=5. Next start -> 0. Forced 70000 starved cycles -> 16'hFFFF.

Source files
------------

// File: rtl/bmc_acs_sched.sv
// Frame sequencer for the K=3 Viterbi BMC/ACS datapath: symbol intake, grouped ACS, tail flush, traceback.
// Optional BMC_SCHED_STALL_CNT_EN adds a saturating input-starvation counter on stall_cnt.
module bmc_acs_sched #(
  parameter int FRAME_LEN = 256,
  parameter int TAIL_LEN  = 2,
  parameter int N_GRP     = 4,
  parameter int ADDR_W    = 9,
  localparam int GRP_W    = (N_GRP > 1) ? $clog2(N_GRP) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_rx_pair,
  output logic [1:0]        bmc_rx_pair,
  output logic              pm_init,
  output logic              acs_en,
  output logic [GRP_W-1:0]  acs_grp,
  output logic              sv_wr_en,
  output logic [ADDR_W-1:0] sv_wr_addr,
  output logic              tb_start,
  input  logic              tb_done,
  output logic              busy,
`ifdef BMC_SCHED_STALL_CNT_EN
  output logic [15:0]       stall_cnt,
`endif
  output logic              frame_done
);

  typedef enum logic [2:0] {
    IDLE, INIT, SYM_WAIT, ACS, FLUSH, TB_LAUNCH, TB_WAIT, DONE
  } state_t;

  localparam logic [GRP_W-1:0]  GRP_LAST  = GRP_W'(N_GRP - 1);
  localparam logic [ADDR_W-1:0] DATA_LAST = ADDR_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W-1:0] STEP_LAST = ADDR_W'(FRAME_LEN + TAIL_LEN - 1);

  state_t            state, state_nxt;
  logic [GRP_W-1:0]  grp;
  logic [ADDR_W-1:0] step;
  logic              grp_last;

  assign grp_last = (grp == GRP_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Group index, trellis step and the pair held on the BMC bus for a whole group sweep
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grp         <= '0;
      step        <= '0;
      bmc_rx_pair <= 2'b00;
    end else begin
      case (state)
        INIT: begin
          grp  <= '0;
          step <= '0;
        end
        SYM_WAIT: begin
          if (in_valid) begin
            bmc_rx_pair <= in_rx_pair;
            grp         <= '0;
          end
        end
        ACS: begin
          if (grp_last) begin
            grp  <= '0;
            step <= step + 1'b1;
          end else begin
            grp <= grp + 1'b1;
          end
        end
        FLUSH: begin
          bmc_rx_pair <= 2'b00;
          grp         <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    pm_init    = 1'b0;
    acs_en     = 1'b0;
    sv_wr_en   = 1'b0;
    tb_start   = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = INIT;
      end
      INIT: begin
        pm_init   = 1'b1;
        state_nxt = SYM_WAIT;
      end
      SYM_WAIT: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ACS;
      end
      ACS: begin
        acs_en = 1'b1;
        if (grp_last) begin
          sv_wr_en = 1'b1;
          if (step < DATA_LAST)      state_nxt = SYM_WAIT;
          else if (step < STEP_LAST) state_nxt = FLUSH;
          else                       state_nxt = TB_LAUNCH;
        end
      end
      FLUSH: begin
        state_nxt = ACS;
      end
      TB_LAUNCH: begin
        tb_start  = 1'b1;
        state_nxt = TB_WAIT;
      end
      TB_WAIT: begin
        if (tb_done) state_nxt = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy       = (state != IDLE);
  assign acs_grp    = acs_en ? grp : '0;
  assign sv_wr_addr = sv_wr_en ? step : '0;

`ifdef BMC_SCHED_STALL_CNT_EN
  // Starvation: waiting for a symbol that the source is not offering
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (state == INIT) begin
      stall_cnt <= '0;
    end else if (state == SYM_WAIT && !in_valid && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bmc_acs_sched.sv
// Self-checking bench for bmc_acs_sched: table-driven frames with a write scoreboard plus reset/abort sequences.
module tb_bmc_acs_sched;
  localparam int FL = 4;
  localparam int TL = 2;
  localparam int NG = 4;
  localparam int AW = 9;
  localparam int GW = 2;
  localparam int NSTEP = FL + TL;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [1:0]    in_rx_pair = 2'b00;
  logic          tb_done = 1'b0;
  logic          in_ready;
  logic [1:0]    bmc_rx_pair;
  logic          pm_init;
  logic          acs_en;
  logic [GW-1:0] acs_grp;
  logic          sv_wr_en;
  logic [AW-1:0] sv_wr_addr;
  logic          tb_start;
  logic          busy;
  logic          frame_done;
`ifdef BMC_SCHED_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  bmc_acs_sched #(
    .FRAME_LEN(FL), .TAIL_LEN(TL), .N_GRP(NG), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_rx_pair(in_rx_pair),
    .bmc_rx_pair(bmc_rx_pair), .pm_init(pm_init), .acs_en(acs_en), .acs_grp(acs_grp),
    .sv_wr_en(sv_wr_en), .sv_wr_addr(sv_wr_addr), .tb_start(tb_start), .tb_done(tb_done),
    .busy(busy),
`ifdef BMC_SCHED_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    rx;
    logic          is_data;
    logic [AW-1:0] exp_addr;
    logic [1:0]    exp_pair;
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [1:0]    pair;
  } exp_t;

  vec_t vecs [NSTEP];
  exp_t sb [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int pm_cnt = 0;
  int last_wr_cyc = 0;
  int exp_grp = 0;
  logic [1:0] held_pair = 2'b00;

  always @(posedge clk) cyc++;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic apply_stimulus(input logic s, input logic v, input logic [1:0] p, input logic d);
    start      = s;
    in_valid   = v;
    in_rx_pair = p;
    tb_done    = d;
  endtask

  task automatic check_all_zero(input string name);
    check_output({name, "_outputs"},
                 32'({in_ready, bmc_rx_pair, pm_init, acs_en, acs_grp, sv_wr_en,
                      sv_wr_addr, tb_start, busy, frame_done}), 32'd0);
`ifdef BMC_SCHED_STALL_CNT_EN
    check_output({name, "_stall_cnt"}, 32'(stall_cnt), 32'd0);
`endif
  endtask

  // Write monitor: every survivor write is matched against the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (pm_init) pm_cnt++;
      if (sv_wr_en) begin
        wr_cnt++;
        last_wr_cyc = cyc;
        if (sb.size() == 0) begin
          check_output("sv_wr_unexpected", 32'(sv_wr_en), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_output("sv_wr_addr", 32'(sv_wr_addr), 32'(e.addr));
          check_output("sv_wr_pair", 32'(bmc_rx_pair), 32'(e.pair));
        end
      end
      if (acs_en) begin
        check_output("acs_grp_seq", 32'(acs_grp), 32'(exp_grp));
        check_output("in_ready_in_acs", 32'(in_ready), 32'd0);
        if (exp_grp == 0) held_pair = bmc_rx_pair;
        else check_output("pair_stable", 32'(bmc_rx_pair), 32'(held_pair));
        exp_grp = (exp_grp == NG - 1) ? 0 : exp_grp + 1;
      end
    end
  end

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check_output({name, "_timeout"}, 32'(in_ready), 32'd1);
  endtask

  task automatic run_frame(input int gap, input bit spurious);
    int prev_acc;
    int n;
    exp_t e;
    wr_cnt = 0;
    pm_cnt = 0;
    prev_acc = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_output("pm_init_after_start", 32'(pm_init), 32'd1);
    @(negedge clk);
    check_output("in_ready_after_init", 32'(in_ready), 32'd1);
`ifdef BMC_SCHED_STALL_CNT_EN
    check_output("stall_cleared", 32'(stall_cnt), 32'd0);
`endif
    for (int k = 0; k < NSTEP; k++) begin
      if (vecs[k].is_data) begin
        wait_ready("in_ready");
        if (k == 2 && gap > 0) begin
          for (int g = 0; g < gap; g++) begin
            check_output("bp_in_ready", 32'(in_ready), 32'd1);
            check_output("bp_no_acs", 32'({acs_en, sv_wr_en}), 32'd0);
            tb_done = spurious && (g == 3);
            @(negedge clk);
          end
          tb_done = 1'b0;
        end else if (k > 0) begin
          check_output("throughput", 32'(cyc - prev_acc), 32'(NG + 1));
        end
        prev_acc = cyc;
        in_valid   = 1'b1;
        in_rx_pair = vecs[k].rx;
        e.addr = vecs[k].exp_addr;
        e.pair = vecs[k].exp_pair;
        sb.push_back(e);
        if (k == FL - 1) begin
          for (int t = FL; t < NSTEP; t++) begin
            e.addr = vecs[t].exp_addr;
            e.pair = vecs[t].exp_pair;
            sb.push_back(e);
          end
        end
        @(negedge clk);
        if ((k == 1 && gap > 0) || k == FL - 1) in_valid = 1'b0;
        if (k == 0 && spurious) begin
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
        end
      end
    end
    n = 0;
    while (!tb_start && n < 60) begin
      @(negedge clk);
      n++;
    end
    check_output("tb_start_seen", 32'(tb_start), 32'd1);
    check_output("tb_start_latency", 32'(cyc - last_wr_cyc), 32'd1);
    check_output("wr_count", 32'(wr_cnt), 32'(NSTEP));
    check_output("sb_empty", 32'(sb.size()), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check_output("tb_wait_hold", 32'({busy, frame_done}), 32'b10);
    end
    tb_done = 1'b1;
    @(negedge clk);
    check_output("frame_done", 32'(frame_done), 32'd1);
    start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    tb_done = 1'b0;
    check_output("done_start_ignored", 32'({busy, frame_done}), 32'd0);
    check_output("pm_init_count", 32'(pm_cnt), 32'd1);
`ifdef BMC_SCHED_STALL_CNT_EN
    check_output("stall_cnt", 32'(stall_cnt), 32'(gap));
`endif
  endtask

  initial begin
    vecs[0] = '{2'b01, 1'b1, 9'd0, 2'b01};
    vecs[1] = '{2'b10, 1'b1, 9'd1, 2'b10};
    vecs[2] = '{2'b11, 1'b1, 9'd2, 2'b11};
    vecs[3] = '{2'b00, 1'b1, 9'd3, 2'b00};
    vecs[4] = '{2'b11, 1'b0, 9'd4, 2'b00};
    vecs[5] = '{2'b11, 1'b0, 9'd5, 2'b00};

    apply_stimulus(1'b1, 1'b1, 2'b11, 1'b1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    apply_stimulus(1'b0, 1'b0, 2'b00, 1'b0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_output("idle_busy_ready", 32'({busy, in_ready}), 32'd0);
    check_all_zero("idle");

    run_frame(0, 1'b0);
    run_frame(7, 1'b1);
    run_frame(5, 1'b0);

    // Abort during the third group cycle of the first symbol
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    wait_ready("abort_ready");
    apply_stimulus(1'b0, 1'b1, 2'b10, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    for (int n = 0; n < 10 && !(acs_en && acs_grp == 2'd2); n++) @(negedge clk);
    check_output("abort_at_grp2", 32'({acs_en, acs_grp}), 32'b110);
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    repeat (2) @(negedge clk);
    check_all_zero("abort_hold");
    rst_n = 1'b1;
    sb.delete();
    exp_grp = 0;
    run_frame(0, 1'b0);

`ifdef BMC_SCHED_STALL_CNT_EN
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check_output("sat_in_ready", 32'(in_ready), 32'd1);
    repeat (70000) @(negedge clk);
    check_output("stall_saturate", 32'(stall_cnt), 32'hFFFF);
    rst_n = 1'b0;
    #1;
    check_all_zero("sat_reset");
    @(negedge clk);
    rst_n = 1'b1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
